// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared FSM state type, protection bit positions and index sizing
package apb_slave_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam int PROT_PRIV = 0;
  localparam int PROT_NONSEC = 1;
  localparam int PROT_INSTR = 2;
  function automatic int idx_width(input int addr_width, input int data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction
endpackage

// File: rtl/apb_slave_fsm.sv
// apb_slave_fsm: APB setup/access sequencing, wait-state counter, ready and abort
module apb_slave_fsm
  import apb_slave_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic sel_i,
  input  logic enable_i,
  output logic setup_o,
  output logic done_next_o,
  output logic ready_o
);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // An access phase without a preceding setup never leaves IDLE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    setup_o = 1'b0;
    unique case (state_q)
      IDLE: if (sel_i && !enable_i) begin
        setup_o = 1'b1;
        state_d = (WAIT_STATES == 0) ? DONE : WAIT;
        cnt_d = CNT_INIT;
      end
      WAIT: begin
        state_d = !sel_i ? IDLE : (cnt_q == 4'd0) ? DONE : WAIT;
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign done_next_o = state_d == DONE;
  assign ready_o = state_q == DONE;
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB4 slave with a bank of byte-strobed registers and access checks
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] SECURE_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           sel,
  input  logic                           enable,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           write,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        strb,
  input  logic [2:0]                     prot,
  input  logic                           other_error,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           ready,
  output logic                           slave_error,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = idx_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int SW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic setup, done_next, in_range, commit, unused;
  logic write_q, write_cur, nonsec_q, nonsec_cur, err_q, err_cur;
  logic [IW-1:0] idx_q, idx_cur;
  logic [SW-1:0] sidx;
  logic [NB-1:0] strb_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_d, merged;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk        (clk),
    .rstn_i     (rstn),
    .sel_i      (sel),
    .enable_i   (enable),
    .setup_o    (setup),
    .done_next_o(done_next),
    .ready_o    (ready)
  );
  // During setup the live bus is decoded; afterwards the latched copy is
  assign idx_cur = setup ? IW'(addr >> LSB) : idx_q;
  assign write_cur = setup ? write : write_q;
  assign nonsec_cur = setup ? prot[PROT_NONSEC] : nonsec_q;
  assign in_range = {1'b0, idx_cur} < (IW+1)'(NUM_REGS);
  assign sidx = SW'(idx_cur);
  assign err_cur = !in_range || (write_cur && RO_MASK[sidx]) || (nonsec_cur && SECURE_MASK[sidx]);
  assign rdata_d = (done_next && !write_cur && !err_cur) ? regs_q[sidx] : '0;
  assign commit = ready && sel && enable && write_q && !err_q && !other_error;
  assign unused = ^{prot, addr};
  always_comb begin
    merged = regs_q[sidx];
    for (int b = 0; b < NB; b++) if (strb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      idx_q <= '0;
      write_q <= 1'b0;
      nonsec_q <= 1'b0;
      err_q <= 1'b0;
      wdata_q <= '0;
      strb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (setup) begin
        idx_q <= idx_cur;
        write_q <= write;
        nonsec_q <= prot[PROT_NONSEC];
        err_q <= err_cur;
        wdata_q <= wdata;
        strb_q <= strb;
      end
      rdata_q <= rdata_d;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (commit) regs_q[sidx] <= merged;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end
  assign rdata = rdata_q;
  assign slave_error = ready & (err_q | other_error);
endmodule
